arith_unit: RTL

Datapath stage driven by the ALU control unit. Holds accumulator A, multiplier/quotient register Q, operand register M, Booth bit Q-1, a 3-bit step counter and a 16-bit result register. Executes the one-cycle micro-operations selected by control strobes c0–c7 and returns the status bits (q0, qm1, a7, cnt_done) the control FSM branches on. Supports add/sub, Booth radix-2 signed multiply and restoring-style divide on 8-bit operands.

---
 rtl/alu_pkg.sv | 15 +
 rtl/addsub_w.sv | 21 ++
 rtl/arith_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: operand width, op encodings and
// step-counter geometry.
package alu_pkg;

  localparam int unsigned W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntTerm = 3'd7;

endpackage

// File: rtl/addsub_w.sv
// W-bit two's-complement adder/subtractor with signed-overflow flag.
module addsub_w #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = a + b_eff + {{(W-1){1'b0}}, sub};
    // Overflow: operands share a sign but the result does not.
    ovf   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  end

endmodule

// File: rtl/arith_unit.sv
// ALU datapath stage: A/Q/M/Q-1 registers, step counter and result register,
// updated by one-cycle micro-op strobes c0..c7 from the control FSM.
module arith_unit
  import alu_pkg::*;
#(
  parameter int unsigned W = alu_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   inbus,
  input  logic [1:0]     op,
  input  logic           c0,
  input  logic           c1,
  input  logic           c2,
  input  logic           c3,
  input  logic           c4,
  input  logic           c5,
  input  logic           c6,
  input  logic           c7,
  output logic           q0,
  output logic           qm1,
  output logic           a7,
  output logic           cnt_done,
  output logic [2*W-1:0] outbus,
  output logic           out_valid,
  output logic           ovf
);

  logic [W-1:0]    a_q, a_d, q_q, q_d, m_q, m_d;
  logic            qm1_q, qm1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  res_q, res_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    sum;
  logic            sum_ovf;
  logic            unused_op_hi;

  // Only op[0] matters here: it picks the shift direction.
  assign unused_op_hi = op[1];

  addsub_w #(
    .W (W)
  ) u_addsub (
    .a   (a_q),
    .b   (m_q),
    .sub (c3),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    m_d     = c1 ? inbus : m_q;
    res_d   = c7 ? {a_q, q_q} : res_q;
    valid_d = c7;

    if (c0) begin
      q_d   = inbus;
      a_d   = '0;
      qm1_d = 1'b0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (c4) begin
        if (op[0]) begin
          {a_d, q_d} = {a_q[W-2:0], q_q, c6};
        end else begin
          {a_d, q_d, qm1_d} = {a_q[W-1], a_q, q_q};
        end
      end else if (c2) begin
        a_d   = sum;
        ovf_d = sum_ovf;
      end
      if (c5) begin
        cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q0        = q_q[0];
  assign qm1       = qm1_q;
  assign a7        = a_q[W-1];
  assign cnt_done  = (cnt_q == CntTerm);
  assign outbus    = res_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;

endmodule
